// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the double-buffered PWM bank.
//   PWM_WIDTH_DEFAULT    : default counter/period/duty width
//   PWM_ADDR_PERIOD_OFS  : period staging address, relative to CHANNELS
//   PWM_ADDR_POL_OFS     : polarity staging address, relative to CHANNELS
//   pwm_addr_w()         : staging address width for a given channel count
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_WIDTH_DEFAULT   = 16;
    localparam int PWM_ADDR_PERIOD_OFS = 0;
    localparam int PWM_ADDR_POL_OFS    = 1;

    // Duty slots 0..CHANNELS-1 plus the period and polarity slots.
    function automatic int pwm_addr_w(input int channels);
        return $clog2(channels + 2);
    endfunction

endpackage

// File: rtl/pwm_compare_ch.sv
// ---------------------------------------------------------------------------
// pwm_compare_ch
// One PWM channel: holds the active duty register (and the active polarity
// bit when PWM_SHADOW_POLARITY_EN is defined) and compares it against the
// shared counter.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   load_i         : copy staging values into the active registers
//   run_i          : counter running; output forced low when 0
//   cnt_i          : shared period counter
//   duty_stage_i   : staging duty value for this channel
//   pol_stage_i    : staging polarity bit (only with PWM_SHADOW_POLARITY_EN)
//   pwm_o          : PWM output
// ---------------------------------------------------------------------------
module pwm_compare_ch
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] duty_stage_i,
`ifdef PWM_SHADOW_POLARITY_EN
    input  logic             pol_stage_i,
`endif
    output logic             pwm_o
);

    logic [WIDTH-1:0] duty_a_q;
    logic             pol_a;

    // Active duty only changes on a load, so a period never mixes values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_a_q <= '0;
        end else if (load_i) begin
            duty_a_q <= duty_stage_i;
        end
    end

`ifdef PWM_SHADOW_POLARITY_EN
    logic pol_a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol_a_q <= 1'b0;
        end else if (load_i) begin
            pol_a_q <= pol_stage_i;
        end
    end

    assign pol_a = pol_a_q;
`else
    assign pol_a = 1'b0;
`endif

    // Unsigned compare: duty 0 never active, duty above period always active.
    assign pwm_o = run_i & ((cnt_i < duty_a_q) ^ pol_a);

endmodule

// File: rtl/pwm_shadow_bank.sv
// ---------------------------------------------------------------------------
// pwm_shadow_bank
// Multi-channel PWM generator with double-buffered period, duty and
// polarity. Writes land in staging registers; a commit arms a reload that is
// applied atomically on the next counter rollover (or at once when idle).
// Optional feature macro: PWM_SHADOW_POLARITY_EN (per-channel polarity).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : run request, registered into run_q
//   wr_en       : staging write strobe
//   wr_addr     : 0..CHANNELS-1 duty, CHANNELS period, CHANNELS+1 polarity
//   wr_data     : staging write data (polarity in bits [CHANNELS-1:0])
//   commit      : arm a staging-to-active reload
//   pending     : reload armed but not yet applied
//   rollover    : last count of the current period
//   cnt         : current counter value
//   pwm_out     : PWM outputs, one per channel
// ---------------------------------------------------------------------------
module pwm_shadow_bank
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH_DEFAULT,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = pwm_addr_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                commit,
    output logic                pending,
    output logic                rollover,
    output logic [WIDTH-1:0]    cnt,
    output logic [CHANNELS-1:0] pwm_out
);

    localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(CHANNELS + PWM_ADDR_PERIOD_OFS);

    logic             run_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             pending_q;
    logic             pending_d;
    logic [WIDTH-1:0] period_s_q;
    logic [WIDTH-1:0] period_a_q;
    logic [WIDTH-1:0] duty_s_q [CHANNELS];
    logic             load;

    assign rollover = run_q && (cnt_q == period_a_q);

    // A load needs an armed (or just-arriving) commit and a safe point:
    // the end of a period while running, or any cycle while idle.
    assign load = (pending_q | commit) & (rollover | ~run_q);

    // Counter wraps after period_a; idle holds it at zero.
    always_comb begin
        cnt_d     = cnt_q + WIDTH'(1);
        pending_d = pending_q | commit;
        if (!run_q || rollover) begin
            cnt_d = '0;
        end
        if (load) begin
            pending_d = 1'b0;
        end
    end

    // Run flag, counter, pending flag and active period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            period_a_q <= '0;
        end else begin
            run_q     <= en;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            if (load) begin
                period_a_q <= period_s_q;
            end
        end
    end

    // Staging writes; the active copies sample the pre-write values on a
    // load edge because both update on the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_s_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_s_q[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_addr == ADDR_PERIOD) begin
                period_s_q <= wr_data;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    duty_s_q[i] <= wr_data;
                end
            end
        end
    end

`ifdef PWM_SHADOW_POLARITY_EN
    localparam logic [ADDR_W-1:0] ADDR_POL = ADDR_W'(CHANNELS + PWM_ADDR_POL_OFS);

    logic [CHANNELS-1:0] pol_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol_s_q <= '0;
        end else if (wr_en && (wr_addr == ADDR_POL)) begin
            pol_s_q <= wr_data[CHANNELS-1:0];
        end
    end
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_compare_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .load_i       (load),
            .run_i        (run_q),
            .cnt_i        (cnt_q),
            .duty_stage_i (duty_s_q[g]),
`ifdef PWM_SHADOW_POLARITY_EN
            .pol_stage_i  (pol_s_q[g]),
`endif
            .pwm_o        (pwm_out[g])
        );
    end

    assign pending = pending_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_pwm_shadow_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_shadow_bank
// Directed bench for pwm_shadow_bank with a behavioural reference model.
// Honours PWM_SHADOW_POLARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pwm_shadow_bank;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int AW = 3;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          en      = 1'b0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          commit  = 1'b0;
    logic          pending;
    logic          rollover;
    logic [W-1:0]  cnt;
    logic [CH-1:0] pwm_out;

    int checks   = 0;
    int failures = 0;

    pwm_shadow_bank #(
        .WIDTH    (W),
        .CHANNELS (CH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .commit   (commit),
        .pending  (pending),
        .rollover (rollover),
        .cnt      (cnt),
        .pwm_out  (pwm_out)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers following the behavioural rules.
    int            mRun     = 0;
    int            mCnt     = 0;
    int            mPend    = 0;
    int            mPerS    = 0;
    int            mPerA    = 0;
    int            mDutyS [CH];
    int            mDutyA [CH];
    logic [CH-1:0] mPolS    = '0;
    logic [CH-1:0] mPolA    = '0;
    int            mRoll;
    int            mLoad;

    initial begin
        for (int i = 0; i < CH; i++) begin
            mDutyS[i] = 0;
            mDutyA[i] = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mRun = 0; mCnt = 0; mPend = 0; mPerS = 0; mPerA = 0;
            mPolS = '0; mPolA = '0;
            for (int i = 0; i < CH; i++) begin
                mDutyS[i] = 0;
                mDutyA[i] = 0;
            end
        end else begin
            mRoll = (mRun != 0 && mCnt == mPerA) ? 1 : 0;
            mLoad = ((mPend != 0 || commit) && (mRoll != 0 || mRun == 0)) ? 1 : 0;
            if (mRun == 0 || mRoll != 0) mCnt = 0;
            else mCnt = mCnt + 1;
            if (mLoad != 0) begin
                mPerA = mPerS;
                mPolA = mPolS;
                for (int i = 0; i < CH; i++) mDutyA[i] = mDutyS[i];
                mPend = 0;
            end else if (commit) begin
                mPend = 1;
            end
            if (wr_en) begin
                if (int'(wr_addr) < CH) mDutyS[int'(wr_addr)] = int'(wr_data);
                else if (int'(wr_addr) == CH) mPerS = int'(wr_data);
`ifdef PWM_SHADOW_POLARITY_EN
                else if (int'(wr_addr) == CH + 1) mPolS = wr_data[CH-1:0];
`endif
            end
            mRun = en ? 1 : 0;
        end
    end

    function automatic int expPwm();
        int e;
        e = 0;
        for (int i = 0; i < CH; i++) begin
            if (mRun != 0 && ((mCnt < mDutyA[i]) ^ mPolA[i])) e = e | (1 << i);
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        checkOutput("cnt", int'(cnt), mCnt);
        checkOutput("rollover", int'(rollover), (mRun != 0 && mCnt == mPerA) ? 1 : 0);
        checkOutput("pending", int'(pending), mPend);
        checkOutput("pwm_out", int'(pwm_out), expPwm());
    end

    task automatic applyStimulus(input int we, input int addr, input int data, input int cmt);
        wr_en   = (we != 0);
        wr_addr = AW'(addr);
        wr_data = W'(data);
        commit  = (cmt != 0);
    endtask

    // Samples one 10-cycle period starting at cnt=0; mode 1 injects a
    // write+commit at cnt=4, mode 2 injects one on the rollover cycle.
    task automatic measurePeriod(input int mode, output int highs, output int rolls,
                                 output int pendLast);
        highs = 0; rolls = 0; pendLast = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 0, 0);
            highs += int'(pwm_out[0]);
            rolls += int'(rollover);
            if (k == 9) pendLast = int'(pending);
            if (mode == 1 && k == 4) applyStimulus(1, 0, 7, 1);
            if (mode == 2 && k == 9) applyStimulus(1, 0, 5, 1);
            @(negedge clk);
        end
        applyStimulus(0, 0, 0, 0);
    endtask

    // Write one staging register with a commit, then wait for the load and
    // the start of a fresh period.
    task automatic stageAndCommit(input int addr, input int data);
        applyStimulus(1, addr, data, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0);
        for (int n = 0; n < 40 && !(pending == 1'b0 && cnt == '0); n++) @(negedge clk);
        if (!(pending == 1'b0 && cnt == '0)) checkOutput("sync_timeout", 1, 0);
    endtask

    initial begin
        int highs, rolls, pendLast;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_cnt", int'(cnt), 0);
        checkOutput("reset_rollover", int'(rollover), 0);
        checkOutput("reset_pwm", int'(pwm_out), 0);
        checkOutput("reset_pending", int'(pending), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Idle load: period 9, duty0 3, commit while en=0.
        applyStimulus(1, CH, 9, 0); @(negedge clk);
        applyStimulus(1, 0, 3, 0);  @(negedge clk);
        applyStimulus(0, 0, 0, 1);  @(negedge clk);
        applyStimulus(0, 0, 0, 0);
        checkOutput("idle_load_pending", int'(pending), 0);
        en = 1'b1;
        @(negedge clk);
        checkOutput("first_cnt", int'(cnt), 0);
        measurePeriod(0, highs, rolls, pendLast);
        checkOutput("idle_highs", highs, 3);
        checkOutput("idle_rolls", rolls, 1);

        // Mid-period reload at cnt=4.
        measurePeriod(1, highs, rolls, pendLast);
        checkOutput("mid_old_highs", highs, 3);
        checkOutput("mid_pending", pendLast, 1);
        checkOutput("mid_pending_clear", int'(pending), 0);

        // Commit with a write on the rollover cycle.
        measurePeriod(2, highs, rolls, pendLast);
        checkOutput("mid_new_highs", highs, 7);
        checkOutput("same_edge_pending", int'(pending), 0);
        measurePeriod(0, highs, rolls, pendLast);
        checkOutput("same_edge_highs", highs, 7);

        // Boundaries.
        stageAndCommit(0, 0);
        measurePeriod(0, highs, rolls, pendLast);
        checkOutput("duty0_highs", highs, 0);
        stageAndCommit(0, 10);
        measurePeriod(0, highs, rolls, pendLast);
        checkOutput("duty10_highs", highs, 10);
        stageAndCommit(CH, 0);
        measurePeriod(0, highs, rolls, pendLast);
        checkOutput("period0_rolls", rolls, 10);

        // Polarity.
        stageAndCommit(CH, 9);
        stageAndCommit(0, 3);
        stageAndCommit(CH + 1, 1);
        measurePeriod(0, highs, rolls, pendLast);
`ifdef PWM_SHADOW_POLARITY_EN
        checkOutput("polarity_highs", highs, 7);
`else
        checkOutput("polarity_highs", highs, 3);
`endif

        // Reset mid-period with a reload pending.
        repeat (4) @(negedge clk);
        applyStimulus(1, 0, 8, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0);
        checkOutput("pre_reset_cnt", int'(cnt), 5);
        checkOutput("pre_reset_pending", int'(pending), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pwm", int'(pwm_out), 0);
        checkOutput("async_reset_pending", int'(pending), 0);
        checkOutput("async_reset_cnt", int'(cnt), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rolls = 0; highs = 0;
        for (int k = 0; k < 5; k++) begin
            rolls += int'(rollover);
            highs += int'(pwm_out != '0);
            @(negedge clk);
        end
        checkOutput("post_reset_rolls", rolls, 5);
        checkOutput("post_reset_pwm", highs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
